// File: rtl/input_scan_scheduler_if.sv
// Bus between the frame strobe / input pads and the scan scheduler.
// master = frame/pad side that drives tick and raw_in; slave = the scheduler.
interface input_scan_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic              tick;
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] ch_en;
    logic              sample_stb;
    logic              busy;
    logic [NUM_CH-1:0] key_state;
    logic [NUM_CH-1:0] key_press;
    logic [NUM_CH-1:0] key_release;
    logic              overrun;

    modport master (
        output tick,
        output raw_in,
        input  ch_en,
        input  sample_stb,
        input  busy,
        input  key_state,
        input  key_press,
        input  key_release,
        input  overrun
    );

    modport slave (
        input  tick,
        input  raw_in,
        output ch_en,
        output sample_stb,
        output busy,
        output key_state,
        output key_press,
        output key_release,
        output overrun
    );
endinterface

// File: rtl/input_scan_scheduler.sv
// Frame-driven channel scanner: one-hot drive, settle, sample, then per-channel
// frame debouncing with press/release pulses. All outputs come straight from flops.
module input_scan_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int SETTLE_CYC   = 1000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input_scan_scheduler_if.slave  bus,
    output logic [1:0]             dbg_state_o
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int DB_W  = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] sample_q, sample_d;

    logic [DB_W-1:0]   db_cnt_q [NUM_CH];
    logic [DB_W-1:0]   db_cnt_d [NUM_CH];

    logic [NUM_CH-1:0] key_state_q, key_state_d;
    logic [NUM_CH-1:0] key_press_q, key_press_d;
    logic [NUM_CH-1:0] key_release_q, key_release_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic              sample_stb_q, sample_stb_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    logic              frame_end;

    // raw_in is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.raw_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        case (state_q)
            S_IDLE: begin
                if (bus.tick) begin
                    state_d = S_SETTLE;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_END) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                sample_d[ch_q] = sync2_q[ch_q];
                if (ch_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                    ch_d    = ch_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        ch_en_d      = '0;
        sample_stb_d = 1'b0;
        busy_d       = 1'b0;
        overrun_d    = 1'b0;
        if ((state_d == S_SETTLE) || (state_d == S_SAMPLE)) begin
            ch_en_d = NUM_CH'(1) << ch_d;
        end
        sample_stb_d = (state_d == S_SAMPLE);
        busy_d       = (state_d != S_IDLE);
        overrun_d    = bus.tick && (state_q != S_IDLE);
    end

    // Debounce is evaluated on the edge entering DONE, so its results are visible during DONE.
    assign frame_end = (state_q == S_SAMPLE) && (ch_q == LAST_CH);

    always_comb begin
        key_state_d   = key_state_q;
        key_press_d   = '0;
        key_release_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
        end
        if (frame_end) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample_d[i] == key_state_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_d[i]      = '0;
                    key_state_d[i]   = ~key_state_q[i];
                    key_press_d[i]   = ~key_state_q[i];
                    key_release_d[i] = key_state_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= '0;
            end
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            ch_en_q       <= '0;
            sample_stb_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            ch_en_q       <= ch_en_d;
            sample_stb_q  <= sample_stb_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.ch_en       = ch_en_q;
    assign bus.sample_stb  = sample_stb_q;
    assign bus.busy        = busy_q;
    assign bus.key_state   = key_state_q;
    assign bus.key_press   = key_press_q;
    assign bus.key_release = key_release_q;
    assign bus.overrun     = overrun_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_input_scan_scheduler.sv
// Directed bench for input_scan_scheduler with NUM_CH=4, SETTLE_CYC=4, DEBOUNCE_CNT=3.
// Cycle T is the cycle tick is held high; outputs are read 1 ns after each rising edge.
module tb_input_scan_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         tests;
    int         fails;

    input_scan_scheduler_if #(.NUM_CH(4)) bus ();

    input_scan_scheduler #(
        .NUM_CH      (4),
        .SETTLE_CYC  (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one full frame; captures DONE-cycle results (offset 21) and any pulses elsewhere.
    task automatic do_frame(output logic [3:0] ks, output logic [3:0] pr, output logic [3:0] rl,
                            output logic [3:0] pr_x, output logic [3:0] rl_x);
        pr_x = '0;
        rl_x = '0;
        ks   = '0;
        pr   = '0;
        rl   = '0;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 21) begin
                ks = bus.key_state;
                pr = bus.key_press;
                rl = bus.key_release;
            end else begin
                pr_x = pr_x | bus.key_press;
                rl_x = rl_x | bus.key_release;
            end
            if (k < 22) cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        tests++;
        if (bus.ch_en !== 4'b0 || bus.busy !== 1'b0 || bus.sample_stb !== 1'b0 ||
            bus.key_state !== 4'b0 || bus.overrun !== 1'b0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_values: ch_en=%b busy=%b stb=%b ks=%b ovr=%b st=%0d, want all 0",
                     bus.ch_en, bus.busy, bus.sample_stb, bus.key_state, bus.overrun, dbg_state);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            tests++;
            if (bus.ch_en !== 4'b0 || bus.busy !== 1'b0 || bus.key_state !== 4'b0) begin
                fails++;
                $display("FAIL idle_cycle%0d: ch_en=%b busy=%b ks=%b, want 0000/0/0000",
                         k, bus.ch_en, bus.busy, bus.key_state);
            end
        end
    endtask

    task automatic test_frame_timing();
        logic [3:0] exp_en;
        logic       exp_stb;
        logic       exp_busy;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            exp_en   = (k <= 20) ? (4'b0001 << ((k - 1) / 5)) : 4'b0000;
            exp_stb  = (k <= 20) && ((k % 5) == 0);
            exp_busy = (k <= 21);
            tests++;
            if (bus.ch_en !== exp_en || bus.sample_stb !== exp_stb || bus.busy !== exp_busy) begin
                fails++;
                $display("FAIL timing_T+%0d: ch_en=%b stb=%b busy=%b, want %b/%b/%b",
                         k, bus.ch_en, bus.sample_stb, bus.busy, exp_en, exp_stb, exp_busy);
            end
            if (k == 21) begin
                tests++;
                if (dbg_state !== 2'd3) begin
                    fails++;
                    $display("FAIL done_state: state=%0d, want 3", dbg_state);
                end
            end
            if (k < 22) cyc();
        end
    endtask

    task automatic test_debounce();
        logic [3:0] ks, pr, rl, prx, rlx;
        bus.raw_in = 4'b0101;
        for (int k = 0; k < 4; k++) cyc();
        for (int f = 1; f <= 2; f++) begin
            do_frame(ks, pr, rl, prx, rlx);
            tests++;
            if (ks !== 4'b0000 || pr !== 4'b0000 || prx !== 4'b0000) begin
                fails++;
                $display("FAIL glitch_frame%0d: ks=%b press=%b other=%b, want 0000/0000/0000",
                         f, ks, pr, prx);
            end
        end
        bus.raw_in = 4'b0000;
        for (int k = 0; k < 4; k++) cyc();
        do_frame(ks, pr, rl, prx, rlx);
        tests++;
        if (ks !== 4'b0000 || pr !== 4'b0000 || prx !== 4'b0000 || rl !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_clear: ks=%b press=%b rel=%b, want 0000/0000/0000", ks, pr, rl);
        end
        bus.raw_in = 4'b0101;
        for (int k = 0; k < 4; k++) cyc();
        for (int f = 1; f <= 3; f++) begin
            do_frame(ks, pr, rl, prx, rlx);
            tests++;
            if (f < 3) begin
                if (ks !== 4'b0000 || pr !== 4'b0000 || prx !== 4'b0000) begin
                    fails++;
                    $display("FAIL press_frame%0d: ks=%b press=%b other=%b, want 0000/0000/0000",
                             f, ks, pr, prx);
                end
            end else begin
                if (ks !== 4'b0101 || pr !== 4'b0101 || prx !== 4'b0000 || rl !== 4'b0000) begin
                    fails++;
                    $display("FAIL press_frame3: ks=%b press=%b other=%b rel=%b, want 0101/0101/0000/0000",
                             ks, pr, prx, rl);
                end
            end
        end
        tests++;
        if (bus.key_press !== 4'b0000 || bus.key_state !== 4'b0101) begin
            fails++;
            $display("FAIL press_after: press=%b ks=%b, want 0000/0101", bus.key_press, bus.key_state);
        end
    endtask

    task automatic test_release();
        logic [3:0] ks, pr, rl, prx, rlx;
        bus.raw_in = 4'b0000;
        for (int k = 0; k < 4; k++) cyc();
        for (int f = 1; f <= 3; f++) begin
            do_frame(ks, pr, rl, prx, rlx);
            tests++;
            if (f < 3) begin
                if (ks !== 4'b0101 || rl !== 4'b0000 || rlx !== 4'b0000) begin
                    fails++;
                    $display("FAIL release_frame%0d: ks=%b rel=%b other=%b, want 0101/0000/0000",
                             f, ks, rl, rlx);
                end
            end else begin
                if (ks !== 4'b0000 || rl !== 4'b0101 || rlx !== 4'b0000 || pr !== 4'b0000) begin
                    fails++;
                    $display("FAIL release_frame3: ks=%b rel=%b other=%b press=%b, want 0000/0101/0000/0000",
                             ks, rl, rlx, pr);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] exp_en;
        bus.raw_in = 4'b0101;
        for (int k = 0; k < 4; k++) cyc();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            bus.tick = (k == 10 || k == 21);
            exp_en = (k <= 20) ? (4'b0001 << ((k - 1) / 5)) : 4'b0000;
            tests++;
            if (bus.ch_en !== exp_en || bus.overrun !== (k == 11 || k == 22) ||
                bus.busy !== (k <= 21)) begin
                fails++;
                $display("FAIL overrun_T+%0d: ch_en=%b ovr=%b busy=%b, want %b/%b/%b",
                         k, bus.ch_en, bus.overrun, bus.busy, exp_en, (k == 11 || k == 22), (k <= 21));
            end
            cyc();
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ks, pr, rl, prx, rlx;
        // Overrun frame left channels 0/2 at count 1; this frame takes them to 2.
        do_frame(ks, pr, rl, prx, rlx);
        tests++;
        if (ks !== 4'b0000 || pr !== 4'b0000) begin
            fails++;
            $display("FAIL premid_frame: ks=%b press=%b, want 0000/0000", ks, pr);
        end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        for (int k = 1; k < 12; k++) cyc();
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.ch_en !== 4'b0 || bus.sample_stb !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_now: ch_en=%b stb=%b busy=%b, want 0000/0/0",
                     bus.ch_en, bus.sample_stb, bus.busy);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            cyc();
            tests++;
            if (bus.key_press !== 4'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL midreset_quiet%0d: press=%b busy=%b, want 0000/0", k, bus.key_press, bus.busy);
            end
        end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        tests++;
        if (bus.ch_en !== 4'b0001) begin
            fails++;
            $display("FAIL restart_ch0: ch_en=%b, want 0001", bus.ch_en);
        end
        for (int k = 1; k < 21; k++) cyc();
        tests++;
        if (bus.key_state !== 4'b0000 || bus.key_press !== 4'b0000) begin
            fails++;
            $display("FAIL restart_done: ks=%b press=%b, want 0000/0000", bus.key_state, bus.key_press);
        end
        cyc();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bus.tick   = 1'b0;
        bus.raw_in = 4'b0000;
        cyc();
        test_reset();
        test_frame_timing();
        test_debounce();
        test_release();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
